// File: rtl/imem_stim_sequencer.sv
// Preloaded instruction-stream player that drives q_imem-style words with per-word hold counts.
// Optional macro STIM_SEQ_PAUSE_EN adds a pause input that freezes playback.
module imem_stim_sequencer #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
`ifdef STIM_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [HOLD_W-1:0] load_hold,
  input  logic             start,
  input  logic             loop_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   count
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [IDX_W:0]    CNT_FULL = DEPTH[IDX_W:0];
  localparam logic [IDX_W:0]    CNT_ONE  = 1;
  localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
  localparam logic [HOLD_W-1:0] HOLD_ONE = 1;

  logic [WIDTH-1:0]  mem_data [DEPTH];
  logic [HOLD_W-1:0] mem_hold [DEPTH];

  state_t            state, state_nxt;
  logic [IDX_W:0]    count_nxt;
  logic [IDX_W-1:0]  index_nxt, idx_inc;
  logic [WIDTH-1:0]  data_nxt;
  logic              valid_nxt, done_nxt, loop_flag, loop_nxt, stall, load_fire;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

`ifdef STIM_SEQ_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign load_ready = (state != PLAY) && (count < CNT_FULL);
  assign load_fire  = load_valid && load_ready && !clear;
  assign busy       = (state == PLAY);
  assign idx_inc    = out_index + IDX_ONE;

  // Program buffer: contents are not reset, only the fill count is.
  always_ff @(posedge clock) begin
    if (load_fire) begin
      mem_data[count[IDX_W-1:0]] <= load_data;
      mem_hold[count[IDX_W-1:0]] <= load_hold;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      out_index <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      hold_cnt  <= '0;
      loop_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      out_index <= index_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      done      <= done_nxt;
      hold_cnt  <= hold_nxt;
      loop_flag <= loop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    index_nxt = out_index;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    done_nxt  = done;
    hold_nxt  = hold_cnt;
    loop_nxt  = loop_flag;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      index_nxt = '0;
      data_nxt  = '0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      hold_nxt  = '0;
      loop_nxt  = 1'b0;
    end else begin
      if (load_fire) count_nxt = count + CNT_ONE;
      case (state)
        IDLE, DONE: begin
          if (start && (count != '0)) begin
            state_nxt = PLAY;
            index_nxt = '0;
            data_nxt  = mem_data[0];
            valid_nxt = 1'b1;
            hold_nxt  = mem_hold[0];
            loop_nxt  = loop_en;
            done_nxt  = 1'b0;
          end
        end
        PLAY: begin
          if (stall) begin
            hold_nxt = hold_cnt;
          end else if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - HOLD_ONE;
          end else if ({1'b0, out_index} < (count - CNT_ONE)) begin
            index_nxt = idx_inc;
            data_nxt  = mem_data[idx_inc];
            hold_nxt  = mem_hold[idx_inc];
          end else if (loop_flag) begin
            // Wrap straight back to slot 0 so the stream has no bubble.
            index_nxt = '0;
            data_nxt  = mem_data[0];
            hold_nxt  = mem_hold[0];
          end else begin
            state_nxt = DONE;
            index_nxt = '0;
            data_nxt  = '0;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stim_sequencer.sv
// Self-checking bench for imem_stim_sequencer: directed steps with randomized programs
// checked against a queue-based model of the expected instruction stream.
module tb_imem_stim_sequencer;
  localparam int WIDTH = 32, DEPTH = 16, HOLD_W = 8, IDX_W = 4;

  logic clock = 1'b0, reset = 1'b0, clear = 1'b0;
  logic load_valid = 1'b0, start = 1'b0, loop_en = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic [HOLD_W-1:0] load_hold = '0;
  logic load_ready, out_valid, busy, done;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0] count;
`ifdef STIM_SEQ_PAUSE_EN
  logic pause = 1'b0;
`endif

  int checks = 0, failures = 0;

  // Reference program: what has been accepted into the buffer.
  logic [WIDTH-1:0]  mdl_data [DEPTH];
  int                mdl_hold [DEPTH];
  int                mdl_count = 0;

  typedef struct { int idx; logic [WIDTH-1:0] data; } elem_t;
  elem_t seq [$];

  imem_stim_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clock(clock), .reset(reset),
`ifdef STIM_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_hold(load_hold), .start(start), .loop_en(loop_en),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [WIDTH-1:0] d, input int h);
    chk("load_ready", load_ready, (mdl_count < DEPTH));
    load_valid = 1'b1; load_data = d; load_hold = h[HOLD_W-1:0];
    tick();
    load_valid = 1'b0;
    if (mdl_count < DEPTH) begin
      mdl_data[mdl_count] = d;
      mdl_hold[mdl_count] = h;
      mdl_count++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    mdl_count = 0;
    chk("clear_count", count, 0);
    chk("clear_valid", out_valid, 0);
    chk("clear_data", out_data, 0);
    chk("clear_done", done, 0);
  endtask

  task automatic build_seq();
    seq.delete();
    for (int i = 0; i < mdl_count; i++)
      for (int r = 0; r <= mdl_hold[i]; r++) seq.push_back('{i, mdl_data[i]});
  endtask

  // Start playback; one-shot runs to completion, looped runs ncyc cycles.
  task automatic play(input bit lp, input int ncyc);
    build_seq();
    loop_en = lp; start = 1'b1; tick(); start = 1'b0; loop_en = 1'b0;
    if (lp) begin
      for (int c = 0; c < ncyc; c++) begin
        chk("loop_valid", out_valid, 1);
        chk("loop_index", out_index, seq[c % seq.size()].idx);
        chk("loop_data", out_data, seq[c % seq.size()].data);
        tick();
      end
    end else begin
      for (int c = 0; c < seq.size(); c++) begin
        chk("play_valid", out_valid, 1);
        chk("play_busy", busy, 1);
        chk("play_index", out_index, seq[c].idx);
        chk("play_data", out_data, seq[c].data);
        tick();
      end
      chk("end_valid", out_valid, 0);
      chk("end_data", out_data, 0);
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] prog [5];
    prog[0] = 32'h00000000; prog[1] = 32'h28400005; prog[2] = 32'h28800003;
    prog[3] = 32'h00C22000; prog[4] = 32'h01022004;

    // Reset held for three cycles
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_count", count, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    tick();

    // Directed load and one-shot
    for (int i = 0; i < 5; i++) load_word(prog[i], 0);
    chk("load5_count", count, 5);
    chk("load5_ready", load_ready, 1);
    chk("load5_valid", out_valid, 0);
    chk("load5_data", out_data, 0);
    play(1'b0, 0);

    // Hold counts
    do_clear();
    load_word(32'h28400005, 2);
    load_word(32'h28800003, 0);
    play(1'b0, 0);

    // Loop with wrap, then clear
    do_clear();
    for (int i = 0; i < 3; i++) load_word(prog[i + 1], 0);
    play(1'b1, 10);
    do_clear();
    chk("loopclr_busy", busy, 0);

    // Randomized programs
    for (int t = 0; t < 6; t++) begin
      int n;
      bit lp;
      n = $urandom_range(1, 7);
      lp = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) load_word($urandom, $urandom_range(0, 3));
      play(lp, 25);
      do_clear();
    end

    // Fill past capacity; extras must be dropped
    for (int i = 0; i < DEPTH + 2; i++) load_word($urandom, $urandom_range(0, 1));
    chk("full_count", count, DEPTH);
    chk("full_ready", load_ready, 0);
    play(1'b0, 0);
    chk("done_ready", load_ready, 0);
    do_clear();

    // Start with empty buffer is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", busy, 0);
    chk("empty_valid", out_valid, 0);
    chk("empty_done", done, 0);
    tick();
    chk("empty_busy2", busy, 0);

    // Start and clear together: clear wins
    load_word(prog[1], 0);
    load_word(prog[2], 0);
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    mdl_count = 0;
    chk("sc_busy", busy, 0);
    chk("sc_count", count, 0);
    chk("sc_valid", out_valid, 0);

`ifdef STIM_SEQ_PAUSE_EN
    // Pause at index 1 stretches it by four cycles
    for (int i = 0; i < 3; i++) load_word(prog[i + 1], 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("pause_idx1", out_index, 1);
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pause_hold_idx", out_index, 1);
      chk("pause_hold_data", out_data, prog[2]);
    end
    pause = 1'b0;
    tick();
    chk("pause_resume", out_index, 2);
    do_clear();
`endif

    // Asynchronous reset between edges at index 2
    for (int i = 0; i < 5; i++) load_word(prog[i], 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("ar_idx2", out_index, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_data", out_data, 0);
    chk("ar_busy", busy, 0);
    tick();
    reset = 1'b1;
    mdl_count = 0;
    tick();
    chk("ar_after_ready", load_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_stim_sequencer.md
Name: imem_stim_sequencer

Overview:
- Parametrised, synthesisable instruction-stream player for processor bring-up benches.
- Preloaded with up to DEPTH words, each with a per-word hold count; on start, it drives them in order onto a q_imem-style output bus.
- Supports one-shot and looped playback, replacing hand-timed instruction assignment.
- Sits between bench control logic and the processor imem input.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, program buffer entries (power of two, >=2).
- HOLD_W, 8, width of the per-word hold count.
- IDX_W, $clog2(DEPTH), index width (derived, not overridden).

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: count<=0, state<=IDLE.
- load_valid  in  1  load handshake valid.
- load_ready  out  1  buffer accepts a load.
- load_data  in  WIDTH  word to append.
- load_hold  in  HOLD_W  extra cycles to hold this word.
- start  in  1  one-cycle pulse, begin playback at index 0.
- loop_en  in  1  sampled at start; 1 = wrap after last word.
- out_valid  out  1  out_data is a programmed word.
- out_data  out  WIDTH  current word (q_imem drive).
- out_index  out  IDX_W  index of current word.
- busy  out  1  state==PLAY.
- done  out  1  one-shot playback finished (sticky until start/clear).
- count  out  IDX_W+1  number of loaded words.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, count=0, out_data=0, out_valid=0, out_index=0, busy=0, done=0, load_ready=1.
  - Hold counter=0, loop flag=0. Buffer contents undefined.
- load_ready = (state!=PLAY) && (count<DEPTH). It is registered-state derived with no combinational path from load_valid.
- Load accepted when load_valid && load_ready:
  - {load_data, load_hold} written to slot count; count increments next cycle.
  - When count==DEPTH, load_ready=0 and further loads are ignored.
- States IDLE, PLAY, DONE:
  - IDLE/DONE + start + count>0 -> PLAY.
    - Next cycle: out_index=0, out_data=buf[0], out_valid=1, hold counter=buf[0].hold, loop flag=loop_en, done=0.
  - start with count==0 is ignored. The state is unchanged and done is unchanged.
  - PLAY: each word is presented for exactly hold+1 cycles (hold=0 -> 1 cycle).
    - When the hold counter is 0 and out_index<count-1: advance to index+1 next cycle and reload the hold.
    - At the last index with the hold expired:
      - loop flag=1: wrap to index 0 with no bubble.
      - loop flag=0: -> DONE next cycle, out_valid=0, out_data=0, done=1.
  - start during PLAY is ignored. Loads during PLAY are refused (load_ready=0).
- clear has priority over start and load in the same cycle.
  - count=0, -> IDLE, out_valid=0, out_data=0, out_index=0, done=0.
- Asserting reset mid-playback aborts immediately to reset values; no partial word persists.
- out_data is 0 whenever out_valid=0. A processor therefore sees NOPs outside playback.
- count width IDX_W+1 represents DEPTH exactly. out_index wraps modulo count, never DEPTH.

Optional Feature:
- Macro STIM_SEQ_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in PLAY, the hold counter and index freeze and out_data/out_valid are held unchanged.
  - Deasserting pause resumes with the remaining hold.
  - pause is ignored outside PLAY. clear and reset override pause.
- Not defined: no port exists and playback never stalls.

Test Plan:
- Reset/load:
  - Stimulus: reset low for 3 cycles, release; load 0x00000000, 0x28400005, 0x28800003, 0x00C22000, 0x01022004, all hold=0.
  - Response: count=5, load_ready=1, all outputs at reset values.
- One-shot:
  - Stimulus: start with loop_en=0.
  - Response: out_data shows the 5 words on 5 consecutive cycles with out_index 0..4, then out_valid=0, out_data=0, done=1, busy=0.
- Hold:
  - Stimulus: reload 2 words, 0x28400005 hold=2 and 0x28800003 hold=0; start.
  - Response: first word on 3 cycles, second on 1 cycle, then done=1.
- Loop/wrap:
  - Stimulus: 3 words hold=0, loop_en=1; run 10 cycles, then clear.
  - Response: out_index sequence 0,1,2,0,1,2,0,1,2,0 with no bubble; after clear, count=0 and out_valid=0.
- Full/boundary:
  - Stimulus: load DEPTH+2 words.
  - Response: count=16, load_ready=0, extra words are dropped.
  - Stimulus: start with count==0.
  - Response: state stays IDLE.
  - Stimulus: start and clear in the same cycle.
  - Response: clear wins.
- Async reset mid-play:
  - Stimulus: pull reset low between clock edges during index 2.
  - Response: out_valid=0, count=0 immediately, without waiting for a clock edge.
  - With STIM_SEQ_PAUSE_EN defined:
    - Stimulus: pause for 4 cycles at index 1.
    - Response: index 1 is extended by 4 cycles.
